// File: rtl/dog_dt_wr_gen.sv
// Frame write address generator: turns a stream of samples into row-major
// and/or column-major memory writes, discarding SKIP fill samples per line.
module dog_dt_wr_gen #(
    parameter int DATA_W = 8,
    parameter int XW     = 8,
    parameter int YW     = 8,
    parameter int SKIP   = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              clear,
    input  logic              wr_valid_in,
    input  logic [DATA_W-1:0] wr_data_in,
    output logic              wr_ready_out,
    input  logic              wr_ready_in,
    output logic              wr_valid_out,
    output logic [XW+YW-1:0]  wr_addr_out,
    output logic [DATA_W-1:0] wr_data_out,
    output logic              busy,
    output logic              done
);

    localparam int MW = (XW > YW) ? XW : YW;
    localparam int PW = ((MW > 8) ? MW : 8) + 1;
    localparam logic signed [PW-1:0] POS_INIT = PW'(-SKIP);
    localparam logic [PW-1:0] W_LAST = PW'((1 << XW) - 1);
    localparam logic [PW-1:0] H_LAST = PW'((1 << YW) - 1);

    typedef enum logic [1:0] {IDLE, ROW, COL, FIN} state_t;

    state_t               state, state_nxt;
    logic signed [PW-1:0] pos, pos_nxt;
    logic [PW-1:0]        line, line_nxt;
    logic [1:0]           mode_q, mode_nxt;
    logic                 active, in_fill, accept, pos_last, line_last;

    assign active  = (state == ROW) || (state == COL);
    assign in_fill = pos[PW-1];

    // Fill samples are swallowed without waiting on the memory side.
    assign wr_ready_out = active && !clear && (in_fill || wr_ready_in);
    assign wr_valid_out = active && !clear && wr_valid_in && !in_fill;
    assign accept       = active && !clear && wr_valid_in && wr_ready_out;
    assign wr_data_out  = wr_data_in;
    assign busy         = (state != IDLE);
    assign done         = (state == FIN);

    assign pos_last  = (state == ROW) ? ($unsigned(pos) == W_LAST) : ($unsigned(pos) == H_LAST);
    assign line_last = (state == ROW) ? (line == H_LAST) : (line == W_LAST);

    always_comb begin
        wr_addr_out = '0;
        if (state == ROW)
            wr_addr_out = {line[YW-1:0], pos[XW-1:0]};
        else if (state == COL)
            wr_addr_out = {pos[YW-1:0], line[XW-1:0]};
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        line_nxt  = line;
        mode_nxt  = mode_q;
        if (clear) begin
            state_nxt = IDLE;
            pos_nxt   = POS_INIT;
            line_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (mode != 2'b00)) begin
                        mode_nxt  = mode;
                        state_nxt = (mode == 2'b10) ? COL : ROW;
                        pos_nxt   = POS_INIT;
                        line_nxt  = '0;
                    end
                end
                ROW, COL: begin
                    if (accept) begin
                        if (pos_last) begin
                            pos_nxt = POS_INIT;
                            if (line_last) begin
                                line_nxt  = '0;
                                state_nxt = ((state == ROW) && (mode_q == 2'b11)) ? COL : FIN;
                            end else begin
                                line_nxt = line + PW'(1);
                            end
                        end else begin
                            pos_nxt = pos + PW'(1);
                        end
                    end
                end
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pos    <= POS_INIT;
            line   <= '0;
            mode_q <= 2'b00;
        end else begin
            state  <= state_nxt;
            pos    <= pos_nxt;
            line   <= line_nxt;
            mode_q <= mode_nxt;
        end
    end

endmodule
